// File: rtl/ahb_slv_sram_pkg.sv
// Shared AHB encodings and small helpers for the SRAM slave.
package ahb_slv_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Little-endian byte-lane enables for a naturally aligned access.
  function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << off;
      HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = off[0];
      HSIZE_WORD: bad = (off != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-organised SRAM: synchronous read, byte-enabled synchronous write, no reset.
module ahb_slv_mem #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]           wdata_i
);

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_slv_sram.sv
// AHB slave backed by on-chip SRAM with configurable wait states, ERROR
// responses for illegal accesses and a per-lane read-after-write bypass.
module ahb_slv_sram
  import ahb_slv_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRST_N,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_e;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              off_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [3:0]              byp_be_q, byp_be_d;
  logic [31:0]             byp_data_q;

  logic                    accept, illegal, commit_wr;
  logic [3:0]              be_cur;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [31:0]             mem_rdata;
  logic                    unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  assign accept = HSEL && HREADY && HTRANS[1] &&
                  (state_q == ST_IDLE || state_q == ST_LAST || state_q == ST_ERR2);

  always_comb begin
    illegal = size_misaligned(HSIZE, HADDR[1:0]);
    if ((HADDR >> (ADDR_WIDTH + 2)) != '0) illegal = 1'b1;
  end

  assign commit_wr = (state_q == ST_LAST) && write_q;
  assign be_cur    = lane_enables(size_q, off_q);
  // Present the incoming address on acceptance so a zero-wait read has data in LAST.
  assign rd_addr   = accept ? HADDR[ADDR_WIDTH+1:2] : addr_q;

  ahb_slv_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk_i   (HCLK),
    .raddr_i (rd_addr),
    .rdata_o (mem_rdata),
    .we_i    (commit_wr),
    .be_i    (be_cur),
    .waddr_i (addr_q),
    .wdata_i (HWDATA)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_LAST;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP   = HRESP_ERROR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (illegal) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES != 0) begin
        state_d = ST_WAIT;
        cnt_d   = WS;
      end else begin
        state_d = ST_LAST;
      end
    end
  end

  // A read accepted on the edge that commits a write to the same word sees stale
  // SRAM output, so the written lanes are captured and merged in its LAST cycle.
  always_comb begin
    byp_be_d = byp_be_q;
    if (accept) begin
      byp_be_d = (commit_wr && !HWRITE && (HADDR[ADDR_WIDTH+1:2] == addr_q)) ? be_cur : '0;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (state_q == ST_LAST && !write_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        HRDATA[8*b +: 8] = byp_be_q[b] ? byp_data_q[8*b +: 8] : mem_rdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      off_q      <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byp_be_q <= byp_be_d;
      if (accept) begin
        addr_q     <= HADDR[ADDR_WIDTH+1:2];
        off_q      <= HADDR[1:0];
        write_q    <= HWRITE;
        size_q     <= HSIZE;
        byp_data_q <= HWDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slv_sram.sv
// Directed bench: three slave instances (0, 2 and 3 wait states) on a shared bus.
module tb_ahb_slv_sram;
  import ahb_slv_sram_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRST_N;
  logic [2:0]  sel;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        block;
  logic        ro [3];
  logic [1:0]  rs [3];
  logic [31:0] rd [3];
  int          cur;
  int          n_chk;
  int          n_fail;

  always #5 HCLK = ~HCLK;

  assign HREADY = block ? 1'b0 : ro[cur];

  ahb_slv_sram #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRST_N(HRST_N), .HSEL(sel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST_SINGLE), .HPROT(4'b0011),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(ro[0]), .HRESP(rs[0]), .HRDATA(rd[0]));

  ahb_slv_sram #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRST_N(HRST_N), .HSEL(sel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST_INCR), .HPROT(4'b0011),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(ro[1]), .HRESP(rs[1]), .HRDATA(rd[1]));

  ahb_slv_sram #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut3 (
    .HCLK(HCLK), .HRST_N(HRST_N), .HSEL(sel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST_SINGLE), .HPROT(4'b0011),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(ro[2]), .HRESP(rs[2]), .HRDATA(rd[2]));

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input int unsigned exp_wait,
                      input logic [1:0] exp_resp, input logic [31:0] exp_rd, input string tag);
    int unsigned waits = 0;
    sel = '0;
    sel[cur] = 1'b1;
    HADDR = a; HTRANS = HTRANS_NONSEQ; HWRITE = w; HSIZE = sz;
    @(negedge HCLK);
    sel = '0; HTRANS = HTRANS_IDLE; HWDATA = wd;
    while (ro[cur] !== 1'b1 && waits < 40) begin
      chk(32'(rs[cur]), 32'(exp_resp), {tag, "_wait_resp"});
      chk(rd[cur], 32'h0, {tag, "_wait_rdata"});
      waits++;
      @(negedge HCLK);
    end
    chk(waits, exp_wait, {tag, "_waits"});
    chk(32'(rs[cur]), 32'(exp_resp), {tag, "_resp"});
    chk(rd[cur], exp_rd, {tag, "_rdata"});
    @(negedge HCLK);
  endtask

  // Zero-wait slave only: write immediately followed by a pipelined word read.
  task automatic pipe_wr_rd(input logic [31:0] wa, input logic [2:0] wsz, input logic [31:0] wd,
                            input logic [31:0] ra, input logic [31:0] exp_rd, input string tag);
    sel = 3'b001;
    HADDR = wa; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HSIZE = wsz;
    @(negedge HCLK);
    chk(32'(ro[0]), 32'h1, {tag, "_wr_ready"});
    HWDATA = wd; HADDR = ra; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
    @(negedge HCLK);
    sel = '0; HTRANS = HTRANS_IDLE;
    chk(32'(ro[0]), 32'h1, {tag, "_rd_ready"});
    chk(32'(rs[0]), 32'(HRESP_OKAY), {tag, "_rd_resp"});
    chk(rd[0], exp_rd, {tag, "_rd_data"});
    @(negedge HCLK);
  endtask

  // Word write of all-ones to 0x10 on the zero-wait slave that must not be accepted.
  task automatic nacc(input logic [1:0] trans, input logic s, input logic blk, input string tag);
    sel = {2'b00, s}; block = blk;
    HADDR = 32'h10; HTRANS = trans; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
    @(negedge HCLK);
    sel = '0; block = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'hFFFF_FFFF;
    chk(32'(ro[0]), 32'h1, {tag, "_ready"});
    chk(32'(rs[0]), 32'(HRESP_OKAY), {tag, "_resp"});
    @(negedge HCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cur = 0; block = 1'b0;
    HRST_N = 1'b0; sel = '0; HADDR = '0; HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0; HSIZE = HSIZE_WORD; HWDATA = '0;
    repeat (2) @(negedge HCLK);
    for (int i = 0; i < 3; i++) begin
      chk(32'(ro[i]), 32'h1, "reset_ready");
      chk(32'(rs[i]), 32'(HRESP_OKAY), "reset_resp");
      chk(rd[i], 32'h0, "reset_rdata");
    end
    HRST_N = 1'b1;
    @(negedge HCLK);

    // zero wait states: basic word write and read
    cur = 0;
    xfer(32'h10, 1'b1, HSIZE_WORD, 32'h1234_5678, 0, HRESP_OKAY, 32'h0, "ws0_wr");
    xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'h1234_5678, "ws0_rd");

    // two wait states: byte merge into lane 3
    cur = 1;
    xfer(32'h10, 1'b1, HSIZE_WORD, 32'h1234_5678, 2, HRESP_OKAY, 32'h0, "ws2_wr");
    xfer(32'h13, 1'b1, HSIZE_BYTE, 32'hABAB_ABAB, 2, HRESP_OKAY, 32'h0, "ws2_wrb");
    xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 2, HRESP_OKAY, 32'hAB34_5678, "ws2_rd");

    // back-to-back write/read bypass on the zero-wait slave
    cur = 0;
    xfer(32'h20, 1'b1, HSIZE_WORD, 32'h5566_7788, 0, HRESP_OKAY, 32'h0, "pre20");
    pipe_wr_rd(32'h20, HSIZE_HALF, 32'h0000_BEEF, 32'h20, 32'h5566_BEEF, "byp_half");
    pipe_wr_rd(32'h22, HSIZE_BYTE, 32'h007E_0000, 32'h20, 32'h557E_BEEF, "byp_byte");
    pipe_wr_rd(32'h24, HSIZE_WORD, 32'hCAFE_F00D, 32'h20, 32'h557E_BEEF, "byp_other");
    xfer(32'h24, 1'b0, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'hCAFE_F00D, "rd24");

    // illegal accesses: two-cycle ERROR, no side effects
    xfer(32'h0, 1'b1, HSIZE_WORD, 32'h1111_2222, 0, HRESP_OKAY, 32'h0, "pre0");
    xfer(32'h2, 1'b0, HSIZE_WORD, 32'h0, 1, HRESP_ERROR, 32'h0, "err_misal");
    xfer(32'h1000, 1'b0, HSIZE_WORD, 32'h0, 1, HRESP_ERROR, 32'h0, "err_range_rd");
    xfer(32'h1000, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 1, HRESP_ERROR, 32'h0, "err_range_wr");
    xfer(32'h0, 1'b0, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'h1111_2222, "rd0_unch");
    xfer(32'h11, 1'b1, HSIZE_HALF, 32'hFFFF_FFFF, 1, HRESP_ERROR, 32'h0, "err_half");
    xfer(32'h10, 1'b0, 3'b011, 32'h0, 1, HRESP_ERROR, 32'h0, "err_size");
    xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'h1234_5678, "rd10_unch");

    // transfers that must not be accepted
    nacc(HTRANS_IDLE, 1'b1, 1'b0, "na_idle");
    nacc(HTRANS_BUSY, 1'b1, 1'b0, "na_busy");
    nacc(HTRANS_NONSEQ, 1'b0, 1'b0, "na_nosel");
    nacc(HTRANS_SEQ, 1'b1, 1'b1, "na_hready");
    xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'h1234_5678, "rd10_na");

    // reset during a write's wait states discards the write
    cur = 2;
    xfer(32'h40, 1'b1, HSIZE_WORD, 32'h0A0B_0C0D, 3, HRESP_OKAY, 32'h0, "ws3_wr");
    sel = 3'b100; HADDR = 32'h40; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
    @(negedge HCLK);
    sel = '0; HTRANS = HTRANS_IDLE; HWDATA = 32'hFFFF_FFFF;
    chk(32'(ro[2]), 32'h0, "rst_in_wait");
    @(negedge HCLK);
    #2 HRST_N = 1'b0;
    #1;
    chk(32'(ro[2]), 32'h1, "rst_ready");
    chk(32'(rs[2]), 32'(HRESP_OKAY), "rst_resp");
    chk(rd[2], 32'h0, "rst_rdata");
    @(negedge HCLK);
    HRST_N = 1'b1;
    @(negedge HCLK);
    xfer(32'h40, 1'b0, HSIZE_WORD, 32'h0, 3, HRESP_OKAY, 32'h0A0B_0C0D, "ws3_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
